// File: rtl/fp_alu_seq.sv
// fp_alu_seq: multi-cycle small-float ALU (ADD / SUB / MUL), default E4M3.
// Alignment and normalisation move one bit per cycle, so latency depends on the data.
// Rounding is truncation toward zero. Exponent 0 means zero; there is no Inf/NaN.
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready high only in IDLE)
//   a, b                    operands {sign, exp, man}
//   alu_ctrl                4'b0001 ADD, 4'b0010 MUL, 4'b0011 SUB (a-b)
//   out_valid/out_ready     result handshake
//   y                       result
//   flags                   {invalid_op, overflow, underflow}
module fp_alu_seq #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   alu_ctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [2:0]   flags
);

    // Internal mantissa: {carry, hidden, MAN_W fraction bits, 2 guard bits}
    localparam int unsigned MW      = MAN_W + 4;
    // Signed working exponent; covers ea+eb-bias+1 and the left-normalise range
    localparam int unsigned EI_W    = EXP_W + 2;
    localparam int unsigned PW      = 2 * MAN_W + 2;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam int unsigned SH_MAX  = MAN_W + 3;

    localparam logic signed [EI_W-1:0] EXP_HI = EI_W'(EXP_MAX);
    localparam logic signed [EI_W-1:0] EXP_LO = EI_W'(1);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_COMPUTE,
        S_NORM,
        S_DONE
    } state_t;

    state_t                  state;
    logic [W-1:0]            a_q;
    logic [W-1:0]            b_q;
    logic [3:0]              op_q;
    logic                    sgn_r;
    logic                    eff_sub;
    logic signed [EI_W-1:0]  exp_r;
    logic [MW-1:0]           man_l;
    logic [MW-1:0]           man_s;
    logic [EXP_W-1:0]        diff;

    // Unpack / swap signals
    logic                    is_mul_c;
    logic                    is_sub_c;
    logic                    op_ok_c;
    logic [EXP_W-1:0]        ea_c;
    logic [EXP_W-1:0]        eb_c;
    logic [MW-1:0]           ma_c;
    logic [MW-1:0]           mb_c;
    logic                    sb_c;
    logic                    a_big_c;
    logic [EXP_W-1:0]        e_big_c;
    logic [EXP_W-1:0]        e_sml_c;
    logic [MW-1:0]           m_big_c;
    logic [MW-1:0]           m_sml_c;
    logic                    s_big_c;
    logic                    s_sml_c;
    logic [EXP_W-1:0]        diff_raw_c;
    logic [EXP_W-1:0]        diff_cap_c;
    logic signed [EI_W-1:0]  mul_exp_c;

    // Compute / normalise / pack signals
    logic [PW-1:0]           prod_c;
    logic [MW-1:0]           prod_int_c;
    logic [MW-1:0]           man_n_c;
    logic signed [EI_W-1:0]  exp_n_c;
    logic                    sgn_n_c;
    logic                    norm_done_c;
    logic [W-1:0]            y_pk_c;
    logic [2:0]              flags_pk_c;

    // Operand decode, hidden-bit insertion and magnitude swap
    always_comb begin
        is_mul_c = (op_q == OP_MUL);
        is_sub_c = (op_q == OP_SUB);
        op_ok_c  = (op_q == OP_ADD) || is_mul_c || is_sub_c;
        ea_c     = a_q[W-2 -: EXP_W];
        eb_c     = b_q[W-2 -: EXP_W];
        ma_c     = (ea_c == '0) ? '0 : {2'b01, a_q[MAN_W-1:0], 2'b00};
        mb_c     = (eb_c == '0) ? '0 : {2'b01, b_q[MAN_W-1:0], 2'b00};
        sb_c     = b_q[W-1] ^ is_sub_c;
        a_big_c  = (a_q[W-2:0] >= b_q[W-2:0]);
        e_big_c  = a_big_c ? ea_c : eb_c;
        e_sml_c  = a_big_c ? eb_c : ea_c;
        m_big_c  = a_big_c ? ma_c : mb_c;
        m_sml_c  = a_big_c ? mb_c : ma_c;
        s_big_c  = a_big_c ? a_q[W-1] : sb_c;
        s_sml_c  = a_big_c ? sb_c : a_q[W-1];
        diff_raw_c = e_big_c - e_sml_c;
        // A zero small operand needs no alignment; beyond SH_MAX shifts it is zero anyway
        if (e_sml_c == '0) begin
            diff_cap_c = '0;
        end else if (32'(diff_raw_c) > SH_MAX) begin
            diff_cap_c = EXP_W'(SH_MAX);
        end else begin
            diff_cap_c = diff_raw_c;
        end
        mul_exp_c = EI_W'(ea_c) + EI_W'(eb_c) - EI_W'(BIAS);
    end

    // Mantissa product, realigned so its binary point sits under the hidden bit
    always_comb begin
        prod_c     = PW'(man_l[MW-2:2]) * PW'(man_s[MW-2:2]);
        prod_int_c = MW'({prod_c, 2'b00} >> MAN_W);
    end

    // One normalisation step; norm_done_c when the stepped value is final
    always_comb begin
        man_n_c     = man_l;
        exp_n_c     = exp_r;
        sgn_n_c     = sgn_r;
        norm_done_c = 1'b1;
        if (man_l == '0) begin
            sgn_n_c = 1'b0;
        end else if (man_l[MW-1]) begin
            man_n_c = man_l >> 1;
            exp_n_c = exp_r + EI_W'(1);
        end else if (!man_l[MW-2]) begin
            man_n_c     = man_l << 1;
            exp_n_c     = exp_r - EI_W'(1);
            norm_done_c = man_l[MW-3];
        end
    end

    // Pack with saturation on overflow and flush on underflow
    always_comb begin
        y_pk_c     = {sgn_n_c, exp_n_c[EXP_W-1:0], man_n_c[MW-3:2]};
        flags_pk_c = 3'b000;
        if (man_n_c == '0) begin
            y_pk_c = '0;
        end else if (exp_n_c > EXP_HI) begin
            y_pk_c     = {sgn_n_c, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            flags_pk_c = 3'b010;
        end else if (exp_n_c < EXP_LO) begin
            y_pk_c     = '0;
            flags_pk_c = 3'b001;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            sgn_r     <= 1'b0;
            eff_sub   <= 1'b0;
            exp_r     <= '0;
            man_l     <= '0;
            man_s     <= '0;
            diff      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= alu_ctrl;
                        in_ready <= 1'b0;
                        state    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (!op_ok_c) begin
                        y         <= '0;
                        flags     <= 3'b100;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        man_l   <= m_big_c;
                        man_s   <= m_sml_c;
                        eff_sub <= s_big_c ^ s_sml_c;
                        diff    <= diff_cap_c;
                        if (is_mul_c) begin
                            sgn_r <= a_q[W-1] ^ b_q[W-1];
                            exp_r <= mul_exp_c;
                            state <= S_COMPUTE;
                        end else begin
                            sgn_r <= s_big_c;
                            exp_r <= EI_W'(e_big_c);
                            state <= (diff_cap_c == '0) ? S_COMPUTE : S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    man_s <= man_s >> 1;
                    diff  <= diff - EXP_W'(1);
                    if (diff == EXP_W'(1)) begin
                        state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (is_mul_c) begin
                        man_l <= prod_int_c;
                    end else if (eff_sub) begin
                        man_l <= man_l - man_s;
                    end else begin
                        man_l <= man_l + man_s;
                    end
                    state <= S_NORM;
                end
                S_NORM: begin
                    man_l <= man_n_c;
                    exp_r <= exp_n_c;
                    sgn_r <= sgn_n_c;
                    if (norm_done_c) begin
                        y         <= y_pk_c;
                        flags     <= flags_pk_c;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: directed vectors for fp_alu_seq (E4M3) with hand-computed results,
// latency, backpressure and mid-operation reset.
module tb_fp_alu_seq;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] alu_ctrl = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic [2:0] flags;

    int n_total = 0;
    int n_bad   = 0;

    fp_alu_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency, check result, then drain.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [3:0] op, input logic [7:0] ey, input logic [2:0] ef,
                          input int elat);
        int lat;
        @(negedge clock);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        alu_ctrl = op;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (out_valid) break;
        end
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".y"}, 32'(y), 32'(ey));
        check({tag, ".flags"}, 32'(flags), 32'(ef));
        @(posedge clock);
        #1;
        check({tag, ".pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int hi_seen;
        repeat (2) @(negedge clock);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.y", 32'(y), 32'd0);
        check("rst.flags", 32'(flags), 32'd0);
        reset_n = 1'b1;

        // Addition / subtraction
        run_op("add_2p2",   8'h40, 8'h40, 4'b0001, 8'h48, 3'b000, 4);
        run_op("add_align3",8'h28, 8'h10, 4'b0001, 8'h29, 3'b000, 7);
        run_op("add_cap",   8'h50, 8'h10, 4'b0001, 8'h50, 3'b000, 10);
        run_op("add_neg",   8'hC8, 8'hD0, 4'b0001, 8'hD4, 3'b000, 5);
        run_op("add_cancel",8'h50, 8'hD0, 4'b0001, 8'h00, 3'b000, 4);
        run_op("sub_lnorm", 8'h41, 8'h40, 4'b0011, 8'h28, 3'b000, 6);
        run_op("sub_neg",   8'h48, 8'h50, 4'b0011, 8'hC8, 3'b000, 5);
        run_op("add_zero",  8'h00, 8'h44, 4'b0001, 8'h44, 3'b000, 4);

        // Multiplication
        run_op("mul_1xm1",  8'h38, 8'hB8, 4'b0010, 8'hB8, 3'b000, 4);
        run_op("mul_2x1p",  8'h40, 8'h39, 4'b0010, 8'h41, 3'b000, 4);
        run_op("mul_negneg",8'hAC, 8'hC0, 4'b0010, 8'h34, 3'b000, 4);
        run_op("mul_zero",  8'h00, 8'h00, 4'b0010, 8'h00, 3'b000, 4);
        run_op("mul_ovf",   8'h77, 8'h77, 4'b0010, 8'h7F, 3'b010, 4);
        run_op("mul_unf",   8'h08, 8'h08, 4'b0010, 8'h00, 3'b001, 4);

        // Invalid opcode
        run_op("bad_op",    8'h40, 8'h40, 4'b0111, 8'h00, 3'b100, 2);

        // Backpressure: result held, new operands ignored
        out_ready = 1'b0;
        @(negedge clock);
        a = 8'h40; b = 8'h40; alu_ctrl = 4'b0001; in_valid = 1'b1;
        @(posedge clock);
        #1 a = 8'h38; b = 8'h38; alu_ctrl = 4'b0010;
        hi_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) hi_seen = 1;
        end
        check("bp.reached", 32'(hi_seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp.y", 32'(y), 32'h48);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp.release_ov", 32'(out_valid), 32'd0);
        check("bp.release_ir", 32'(in_ready), 32'd1);
        run_op("bp.after",  8'h38, 8'hB8, 4'b0010, 8'hB8, 3'b000, 4);

        // Reset during ALIGN aborts the operation
        @(negedge clock);
        a = 8'h50; b = 8'h10; alu_ctrl = 4'b0001; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check("rst_mid.in_ready", 32'(in_ready), 32'd1);
        check("rst_mid.y", 32'(y), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        hi_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (out_valid) hi_seen = 1;
        end
        check("rst_mid.no_result", 32'(hi_seen), 32'd0);
        run_op("rst_mid.next", 8'h28, 8'h10, 4'b0001, 8'h29, 3'b000, 7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_alu_seq.md
# fp_alu_seq

Parametrised, multi-cycle floating-point ALU for the small-float datapath, successor to the fixed FP8 `alu`. Supports sign/exponent/mantissa widths set by parameters (default E4M3) and performs ADD, SUB and MUL. Operands enter through a valid/ready handshake, and results leave through one. Alignment and normalisation are iterative, one bit per cycle, so latency depends on the data.

## Interface
- `EXP_W`, 4: exponent field width; bias = 2^(EXP_W-1)-1
- `MAN_W`, 3: stored mantissa width (hidden bit implied)
- `W`, 1+EXP_W+MAN_W: operand/result width (derived, not overridable)
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands and op presented
- `in_ready`  out  1  block can accept; high only in IDLE
- `a`, `b`  in  W  operands {sign, exp, man}
- `alu_ctrl`  in  4  op: 4'b0001 ADD, 4'b0010 MUL, 4'b0011 SUB (a-b); others invalid
- `out_valid`  out  1  `y`/`flags` valid
- `out_ready`  in  1  consumer accepts result
- `y`  out  W  result
- `flags`  out  3  {invalid_op, overflow, underflow}

## Operation
- Format: exponent field 0 means zero; subnormals are flushed to zero on input. There is no Inf/NaN, so exponent all-ones is an ordinary finite value.
- Rounding: truncation toward zero. Internal mantissa is MAN_W+4 bits (carry, hidden, MAN_W, 2 guard). Guard bits are dropped at pack.
- FSM: IDLE -> UNPACK -> ALIGN -> COMPUTE -> NORM -> DONE -> IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `a`, `b` and `alu_ctrl`, then go to UNPACK.
- UNPACK (1 cycle):
  - Insert the hidden bit and compute the exponent difference.
  - For SUB, invert the sign of b.
  - Swap operands so the larger magnitude is the primary operand.
  - If the op is invalid, go directly to DONE with `y`=0 and invalid_op=1.
- ALIGN (ADD/SUB only):
  - Each cycle, shift the smaller mantissa right 1 bit and decrement the difference.
  - Leave when the difference is 0, or after MAN_W+3 shifts (the operand is then zero).
  - MUL skips ALIGN.
- COMPUTE (1 cycle):
  - ADD/SUB: signed-magnitude add or subtract of the mantissas; result sign = sign of the larger magnitude.
  - MUL: sign = XOR of the signs; exponent = ea+eb-bias; mantissa = (MAN_W+1)x(MAN_W+1) product, truncated into the internal width.
- NORM: one action per cycle.
  - Carry set: shift right by 1 and increment the exponent.
  - Else, hidden bit clear and mantissa nonzero: shift left by 1 and decrement the exponent.
  - Mantissa zero: result is +0 (sign cleared).
  - Leave when normalised or zero.
- Pack (on entry to DONE):
  - Exponent > 2^EXP_W-1: `y` = {sign, all ones, all ones}, overflow=1.
  - Exponent < 1: `y`=0, underflow=1.
- DONE:
  - `out_valid`=1, with `y`/`flags` held stable.
  - On `out_valid & out_ready`, go to IDLE.
  - No new operand is accepted until IDLE.
- Operands whose exponent field is 0 count as exact zero (MUL gives +0; ADD returns the other operand).

## Timing
- Reset (async assert, sync-release usage) values:
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `y`=0, `flags`=0.
  - All internal registers cleared.
- Reset mid-operation aborts the operation immediately; the result is never presented.
- Latency, counted in cycles from the accept edge to the first edge with `out_valid`=1:
  - Formula: 3 + d + n, where d = ALIGN cycles and n = NORM cycles.
  - Worst case: 2*(MAN_W+3)+3.
  - E4M3: ADD of equal exponents with no cancellation = 4 cycles; MUL ≤ 4 cycles.
- `in_ready` drops the cycle after accept and returns the cycle after the output handshake.
- Throughput: at most one operation in flight.
- `out_ready` held low: `out_valid`, `y` and `flags` stay constant indefinitely.
- `out_ready` high while in DONE: a one-cycle `out_valid` pulse is legal.

## Test plan
- ADD 0x40+0x40 (2+2), `out_ready`=1 -> `y`=0x48, flags=0, `out_valid` exactly 4 cycles after accept.
- ADD sequence, each case checked for result and `out_valid` timing:
  - 0x28+0x10 -> 0x29 (ALIGN 3 cycles)
  - 0x50+0x10 -> 0x50
  - 0xC8+0xD0 -> 0xD4
- Cancellation:
  - ADD 0x50+0xD0 -> 0x00 (+0).
  - SUB 0x41-0x40 -> 0x28 (left-normalise 3 cycles).
  - SUB 0x48-0x50 -> 0xC8.
- MUL:
  - 0x38*0xB8 -> 0xB8.
  - 0x40*0x39 -> 0x41.
  - 0xAC*0xC0 -> 0x34.
  - 0x00*0x00 -> 0x00.
  - 0x77*0x77 -> 0x7F, overflow=1.
  - 0x08*0x08 -> 0x00, underflow=1.
- `alu_ctrl`=4'b0111 -> `y`=0, flags=3'b100, `out_valid` 2 cycles after accept.
- Backpressure and reset:
  - `out_ready` low 10 cycles -> `y` stable, `in_ready`=0, `in_valid` ignored.
  - `reset_n` pulsed low during ALIGN -> `out_valid`=0, `in_ready`=1 immediately; next op completes correctly.
